// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the multi-cycle RV32I sequencer
//
// Purpose: sequencer state enum, RV32I major opcodes, wb_sel encodings,
//          ECALL/EBREAK encodings and the one-hot instruction class type
//          produced by opcode_classifier.
// Ports:   none (package).
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } seq_state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_IMM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_MEM = 2'd3;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // One bit per RV32I instruction class; exactly one is set for a legal opcode.
  typedef struct packed {
    logic op;
    logic op_imm;
    logic lui;
    logic auipc;
    logic load;
    logic store;
    logic jal;
    logic jalr;
    logic branch;
    logic fence;
    logic system;
  } instr_class_t;

  function automatic logic is_env_trap(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - RV32I major opcode to one-hot instruction class
//
// Purpose: combinational decode of instruction[6:0] into an instr_class_t
//          one-hot vector plus an illegal flag; shared with the decoder.
// Ports:
//   opcode  - in,  7: instruction[6:0]
//   cls     - out, instr_class_t: one-hot class, all zero when illegal
//   illegal - out, 1: opcode is not an RV32I major opcode
module opcode_classifier
  import cpu_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP:     cls.op     = 1'b1;
      OPC_OP_IMM: cls.op_imm = 1'b1;
      OPC_LUI:    cls.lui    = 1'b1;
      OPC_AUIPC:  cls.auipc  = 1'b1;
      OPC_LOAD:   cls.load   = 1'b1;
      OPC_STORE:  cls.store  = 1'b1;
      OPC_JAL:    cls.jal    = 1'b1;
      OPC_JALR:   cls.jalr   = 1'b1;
      OPC_BRANCH: cls.branch = 1'b1;
      OPC_FENCE:  cls.fence  = 1'b1;
      OPC_SYSTEM: cls.system = 1'b1;
      default:    illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control FSM for the RV32I core
//
// Purpose: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and owns every
//          write enable and mux select of the datapath. Optional performance
//          counters are built only when SEQ_PERF_EN is defined; otherwise
//          cycle_count and instret are tied to zero.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   instruction       - IR contents (opcode, funct3, full word for ECALL/EBREAK)
//   branch_taken      - branch comparator result, used in EXECUTE
//   mem_ready         - data memory done, used in MEMORY only
//   pc_write, pc_sel  - PC load enable, 0 = pc+4 / 1 = alu_result
//   ir_write          - IR load enable
//   reg_write         - register file write enable
//   mem_read/write    - data memory requests
//   op_a_sel          - 0 = pc, 1 = rs1
//   op_b_sel          - 0 = rs2, 1 = imm
//   alu_force_add     - override decoder alu_op with ADD
//   wb_sel            - 0 = imm, 1 = alu, 2 = pc+4, 3 = mem
//   halted, state     - sticky halt flag, current state (debug)
//   cycle_count       - non-halted cycles since reset
//   instret           - retired instructions (cycles with pc_write)
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             op_a_sel,
  output logic             op_b_sel,
  output logic             alu_force_add,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  seq_state_t   state_q, state_d;
  instr_class_t cls;
  logic         illegal;
  logic         stop_at_decode;
  logic         sel_a_rs1;
  logic         sel_b_imm;
  logic         is_jump;

  opcode_classifier u_opcode_classifier (
    .opcode  (instruction[6:0]),
    .cls     (cls),
    .illegal (illegal)
  );

  // ECALL/EBREAK are the only SYSTEM encodings in RV32I; any other SYSTEM
  // word (CSR access etc.) is unsupported by this core and halts as well.
  assign stop_at_decode = illegal | is_env_trap(instruction) | cls.system;

  // Operand selects chosen in EXECUTE and held through MEMORY/WRITEBACK.
  assign sel_a_rs1 = cls.op | cls.op_imm | cls.load | cls.store | cls.jalr;
  assign sel_b_imm = cls.op_imm | cls.lui | cls.auipc | cls.load | cls.store
                   | cls.jal | cls.jalr | cls.branch;
  assign is_jump   = cls.jal | cls.jalr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    op_a_sel      = 1'b0;
    op_b_sel      = 1'b0;
    alu_force_add = 1'b0;
    wb_sel        = WB_IMM;

    case (state_q)
      ST_FETCH: begin
        ir_write = 1'b1;
        state_d  = ST_DECODE;
      end

      ST_DECODE: begin
        state_d = stop_at_decode ? ST_HALT : ST_EXECUTE;
      end

      ST_EXECUTE: begin
        op_a_sel      = sel_a_rs1;
        op_b_sel      = sel_b_imm;
        alu_force_add = is_jump | cls.branch;
        if (cls.op | cls.op_imm | cls.lui | cls.auipc | is_jump) begin
          state_d = ST_WRITEBACK;
        end else if (cls.load | cls.store) begin
          state_d = ST_MEMORY;
        end else if (cls.branch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken;
          state_d  = ST_FETCH;
        end else if (cls.fence) begin
          pc_write = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          // Unreachable past DECODE; parks the FSM if the IR changes under us.
          state_d = ST_HALT;
        end
      end

      ST_MEMORY: begin
        op_a_sel  = sel_a_rs1;
        op_b_sel  = sel_b_imm;
        mem_read  = cls.load;
        mem_write = cls.store;
        if (mem_ready) begin
          if (cls.load) begin
            state_d = ST_WRITEBACK;
          end else if (cls.store) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_HALT;
          end
        end
      end

      ST_WRITEBACK: begin
        reg_write     = 1'b1;
        pc_write      = 1'b1;
        pc_sel        = is_jump;
        op_a_sel      = sel_a_rs1;
        op_b_sel      = sel_b_imm;
        alu_force_add = is_jump;
        if (cls.lui) begin
          wb_sel = WB_IMM;
        end else if (is_jump) begin
          wb_sel = WB_PC4;
        end else if (cls.load) begin
          wb_sel = WB_MEM;
        end else begin
          wb_sel = WB_ALU;
        end
        state_d = ST_FETCH;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Reset masks everything combinationally so a request in flight (e.g. a
    // store waiting in MEMORY) drops in the same cycle reset is raised.
    if (reset) begin
      pc_write      = 1'b0;
      pc_sel        = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      op_a_sel      = 1'b0;
      op_b_sel      = 1'b0;
      alu_force_add = 1'b0;
      wb_sel        = WB_IMM;
    end
  end

  assign halted = (state_q == ST_HALT);
  assign state  = state_q;

`ifdef SEQ_PERF_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != ST_HALT) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (pc_write) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign cycle_count = cycle_q;
  assign instret     = instret_q;
`else
  assign cycle_count = '0;
  assign instret     = '0;
`endif

endmodule
